// File: rtl/kernel_cc_arb_pkg.sv
// kernel_cc_arb_pkg
//   Shared types and helpers for the kernel_cc FIFO round-robin arbiter.
//   Contents:
//     arb_state_t  arbiter FSM state (ARB_IDLE: no owner, ARB_HOLD: burst owner)
//     STAT_WIDTH   width of each per-requester grant counter
//     MAX_REQ      largest requester count the picker supports
//     pick_t       {found, idx} result of a rotating-priority search
//     rr_pick      rotating-priority search over up to MAX_REQ requesters
package kernel_cc_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 32;
  localparam int MAX_REQ    = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Scans ptr, ptr+1, ... modulo n_req and returns the first requester with
  // data. ptr is always below n_req, so one subtraction is enough to wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [3:0]         ptr,
                                    input int                 n_req);
    pick_t      res;
    logic [3:0] cand;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n_req) begin
        cand = (int'(ptr) + k >= n_req) ? 4'(int'(ptr) + k - n_req)
                                        : 4'(int'(ptr) + k);
        if (!res.found && req[cand]) begin
          res.found = 1'b1;
          res.idx   = cand;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/kernel_cc_rr_pick.sv
// kernel_cc_rr_pick
//   Combinational rotating-priority encoder: finds the first asserted request
//   starting at ptr and wrapping at N_REQ-1 -> 0.
//   Ports:
//     req    in   N_REQ     request vector (one bit per requester)
//     ptr    in   ID_WIDTH  index with highest priority this cycle
//     found  out  1         at least one request is asserted
//     idx    out  ID_WIDTH  index of the selected requester (0 when !found)
module kernel_cc_rr_pick
  import kernel_cc_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  pick_t res;

  // Widen to the package helper's fixed interface, then narrow the index back.
  always_comb begin
    res   = rr_pick(16'(req), 4'(ptr), N_REQ);
    found = res.found;
    idx   = ID_WIDTH'(res.idx);
  end

endmodule

// File: rtl/kernel_cc_fifo_rr_arbiter.sv
// kernel_cc_fifo_rr_arbiter
//   Merges N_REQ HLS-style FIFO read ports into one FIFO write port. Requesters
//   are served round-robin with bursts of up to BURST_LEN words, followed by a
//   single output register stage (1 cycle latency, 1 word/cycle throughput).
//   Ports:
//     clk          in   1               clock
//     reset        in   1               synchronous, active-high reset
//     in_empty_n   in   N_REQ           per-requester data-available flag
//     in_read      out  N_REQ           per-requester pop strobe (one-hot or zero)
//     in_dout      in   N_REQ*DW        requester payloads, requester i at [i*DW +: DW]
//     out_full_n   in   1               downstream FIFO has space
//     out_write    out  1               output register holds valid data
//     out_din      out  DW              output payload
//     out_src      out  ID_WIDTH        requester that produced out_din
//     stat_grants  out  N_REQ*32        per-requester word counts, only present
//                                       when KERNEL_CC_ARB_STATS_EN is defined
module kernel_cc_fifo_rr_arbiter
  import kernel_cc_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              in_empty_n,
  output logic [N_REQ-1:0]              in_read,
  input  logic [N_REQ*DATA_WIDTH-1:0]   in_dout,
  input  logic                          out_full_n,
  output logic                          out_write,
  output logic [DATA_WIDTH-1:0]         out_din,
  output logic [ID_WIDTH-1:0]           out_src
`ifdef KERNEL_CC_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_WIDTH-1:0]   stat_grants
`endif
);

  localparam int                 CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(N_REQ - 1);

  arb_state_t              state_q;
  logic [ID_WIDTH-1:0]     owner_q;
  logic [ID_WIDTH-1:0]     ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    vld_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [ID_WIDTH-1:0]     src_q;

  logic                    adv;
  logic                    owner_ok;
  logic                    pick_found;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic                    grant_valid;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic [ID_WIDTH-1:0]     next_ptr;
  logic [DATA_WIDTH-1:0]   grant_data;

  // Round-robin search always starts at ptr_q. While a burst is running ptr_q
  // already points past the owner, so the owner has lowest priority on release.
  kernel_cc_rr_pick #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (in_empty_n),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Grant decision: keep the current owner while it has data and burst budget,
  // otherwise fall through to the round-robin pick in the same cycle.
  always_comb begin
    adv         = !vld_q || out_full_n;
    owner_ok    = (state_q == ARB_HOLD) && in_empty_n[owner_q] && (cnt_q < BURST_MAX);
    grant_valid = owner_ok || pick_found;
    grant_idx   = owner_ok ? owner_q : pick_idx;
    next_ptr    = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
  end

  // Pop strobe is suppressed in the reset cycle so no word is lost to reset.
  always_comb begin
    in_read = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!reset && adv && grant_valid && (grant_idx == ID_WIDTH'(i))) begin
        in_read[i] = 1'b1;
      end
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        grant_data = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbiter FSM plus output register. Everything only moves on adv, so a
  // stalled output freezes the owner, burst count and held word together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (adv) begin
      if (grant_valid) begin
        vld_q  <= 1'b1;
        data_q <= grant_data;
        src_q  <= grant_idx;
        if (owner_ok) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          ptr_q   <= next_ptr;
          owner_q <= pick_idx;
          cnt_q   <= CNT_W'(1);
          state_q <= (BURST_LEN > 1) ? ARB_HOLD : ARB_IDLE;
        end
      end else begin
        vld_q   <= 1'b0;
        cnt_q   <= '0;
        state_q <= ARB_IDLE;
      end
    end
  end

  always_comb begin
    out_write = vld_q;
    out_din   = data_q;
    out_src   = src_q;
  end

`ifdef KERNEL_CC_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [N_REQ];

  // Per-requester pop counters; they wrap naturally at 2^STAT_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (in_read[i]) begin
          stat_q[i] <= stat_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_grants[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_kernel_cc_fifo_rr_arbiter.sv
// tb_kernel_cc_fifo_rr_arbiter
//   Self-checking bench for kernel_cc_fifo_rr_arbiter (N_REQ=4, BURST_LEN=4).
//   Requesters are queue-backed FIFOs; a reference arbiter predicts each pop,
//   pushes the expected word into a scoreboard and the scoreboard is compared
//   against out_din/out_src while out_write is high.
//   Honors KERNEL_CC_ARB_STATS_EN when defined.
module tb_kernel_cc_fifo_rr_arbiter;
  import kernel_cc_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int BURST = 4;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      in_empty_n = '0;
  logic [N-1:0]      in_read;
  logic [N*DW-1:0]   in_dout = '0;
  logic              out_full_n = 1'b1;
  logic              out_write;
  logic [DW-1:0]     out_din;
  logic [IDW-1:0]    out_src;
`ifdef KERNEL_CC_ARB_STATS_EN
  logic [N*STAT_WIDTH-1:0] stat_grants;
`endif

  kernel_cc_fifo_rr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BURST),
    .ID_WIDTH   (IDW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_empty_n (in_empty_n),
    .in_read    (in_read),
    .in_dout    (in_dout),
    .out_full_n (out_full_n),
    .out_write  (out_write),
    .out_din    (out_din),
    .out_src    (out_src)
`ifdef KERNEL_CC_ARB_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] req_fifo [N][$];

  typedef struct {
    int            src;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb_q[$];
  int  log_q[$];

  // Reference arbiter state (value after the most recent clock edge).
  int          m_ptr   = 0;
  int          m_owner = 0;
  int          m_cnt   = 0;
  bit          m_vld   = 1'b0;
  bit          m_hold  = 1'b0;
  int unsigned m_stat [N];
  int          word_seq = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      in_empty_n[i] = (req_fifo[i].size() > 0);
      in_dout[i*DW +: DW] = (req_fifo[i].size() > 0) ? req_fifo[i][0] : '0;
    end
  endtask

  task automatic applyStimulus(input int r, input int count);
    for (int k = 0; k < count; k++) begin
      req_fifo[r].push_back((64'(r) << 48) | 64'(word_seq));
      word_seq++;
    end
    drive_inputs();
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < N; i++) req_fifo[i].delete();
    drive_inputs();
  endtask

  // One clock: check at the falling edge, predict the next state, then
  // apply the pops the DUT requested just after the rising edge.
  task automatic tick();
    int           g;
    bit           cont;
    bit           adv;
    logic [N-1:0] exp_read;
    logic [N-1:0] rd;
    @(negedge clk);
    checkOutput("out_write", 64'(out_write), 64'(m_vld));
    if (m_vld && sb_q.size() > 0) begin
      checkOutput("out_din", out_din, sb_q[0].data);
      checkOutput("out_src", 64'(out_src), 64'(sb_q[0].src));
    end
    checkOutput("ptr", 64'(dut.ptr_q), 64'(m_ptr));
    if (m_hold) checkOutput("cnt", 64'(dut.cnt_q), 64'(m_cnt));
`ifdef KERNEL_CC_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      checkOutput("stat_grants", 64'(stat_grants[i*STAT_WIDTH +: STAT_WIDTH]), 64'(m_stat[i]));
`endif
    g    = -1;
    cont = 1'b0;
    adv  = !m_vld || out_full_n;
    if (!reset && adv) begin
      if (m_hold && in_empty_n[m_owner] && m_cnt < BURST) begin
        g    = m_owner;
        cont = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && in_empty_n[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
    end
    exp_read = '0;
    if (g >= 0) exp_read[g] = 1'b1;
    checkOutput("in_read", 64'(in_read), 64'(exp_read));
    if (reset) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_vld = 1'b0; m_hold = 1'b0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
      sb_q.delete();
    end else begin
      if (m_vld && out_full_n && sb_q.size() > 0) begin
        log_q.push_back(sb_q[0].src);
        void'(sb_q.pop_front());
      end
      if (adv) begin
        if (g >= 0) begin
          sb_q.push_back('{src: g, data: req_fifo[g][0]});
          m_vld = 1'b1;
          m_stat[g]++;
          if (cont) begin
            m_cnt++;
          end else begin
            m_ptr   = (g + 1) % N;
            m_owner = g;
            m_cnt   = 1;
            m_hold  = (BURST > 1);
          end
        end else begin
          m_vld  = 1'b0;
          m_hold = 1'b0;
        end
      end
    end
    rd = in_read;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i] && req_fifo[i].size() > 0) void'(req_fifo[i].pop_front());
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    clear_fifos();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    log_q.delete();
  endtask

  // Runs until 'need' words have left the arbiter or the cycle budget expires.
  task automatic run_until(input int need, input int budget);
    for (int c = 0; c < budget && log_q.size() < need; c++) tick();
    checkOutput("words_done", 64'(log_q.size() >= need), 64'(1));
  endtask

  initial begin
    logic [DW-1:0] held_din;
    logic [63:0]   held_cnt;

    // 1: idle after reset
    $display("[TB] test 1: reset and idle");
    do_reset();
    checkOutput("rst_out_din", out_din, 64'(0));
    checkOutput("rst_out_src", 64'(out_src), 64'(0));
    checkOutput("rst_in_read", 64'(in_read), 64'(0));
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("idle_state", 64'(dut.state_q), 64'(ARB_IDLE));
    end

    // 2: all ready, full-rate round-robin bursts
    $display("[TB] test 2: all requesters ready");
    do_reset();
    for (int r = 0; r < N; r++) applyStimulus(r, 8);
    run_until(17, 40);
    for (int k = 0; k < 17 && k < log_q.size(); k++)
      checkOutput($sformatf("rr_src[%0d]", k), 64'(log_q[k]), 64'((k / 4) % 4));

    // 3: short burst from req1 hands over to req2 without a bubble
    $display("[TB] test 3: short burst release");
    do_reset();
    applyStimulus(1, 2);
    applyStimulus(2, 4);
    run_until(6, 20);
    for (int k = 0; k < 6 && k < log_q.size(); k++)
      checkOutput($sformatf("short_src[%0d]", k), 64'(log_q[k]), 64'((k < 2) ? 1 : 2));

    // 4: downstream stall in the middle of a burst
    $display("[TB] test 4: output stall");
    do_reset();
    for (int r = 0; r < N; r++) applyStimulus(r, 8);
    repeat (6) tick();
    out_full_n = 1'b0;
    held_din = out_din;
    held_cnt = 64'(dut.cnt_q);
    repeat (5) tick();
    checkOutput("stall_din", out_din, held_din);
    checkOutput("stall_cnt", 64'(dut.cnt_q), held_cnt);
    out_full_n = 1'b1;
    run_until(20, 40);

    // 5: single requester, bursts of 4+4+1
    $display("[TB] test 5: lone requester 3");
    do_reset();
    applyStimulus(3, 9);
    run_until(9, 30);
    for (int k = 0; k < 9 && k < log_q.size(); k++)
      checkOutput($sformatf("lone_src[%0d]", k), 64'(log_q[k]), 64'(3));
    checkOutput("lone_ptr", 64'(dut.ptr_q), 64'(0));

    // 6: reset while the output register is full
    $display("[TB] test 6: reset mid-burst");
    do_reset();
    for (int r = 0; r < N; r++) applyStimulus(r, 8);
    repeat (3) tick();
    checkOutput("pre_rst_write", 64'(out_write), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("post_rst_write", 64'(out_write), 64'(0));
    checkOutput("post_rst_ptr", 64'(dut.ptr_q), 64'(0));
`ifdef KERNEL_CC_ARB_STATS_EN
    checkOutput("post_rst_stats", 64'(stat_grants != '0), 64'(0));
`endif
    repeat (8) tick();

    // Drain and confirm nothing is left in flight
    clear_fifos();
    repeat (4) tick();
    checkOutput("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
